// File: rtl/reg_file32.sv
// reg_file32: 2-read/1-write register file, r0 hardwired to zero, write-through bypass
module reg_file32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                        wr_en;

    assign wr_en = we_i && (wa_i != '0);

    // Next array contents: only the addressed non-zero register takes the write data
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wa_i] = wd_i;
    end

    // Storage; reset clears every register without waiting for a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    // Read ports: r0 reads zero, a same-cycle write bypasses the array, bypass is off in reset
    always_comb begin
        rd1_o = (ra1_i == '0) ? '0 : (rst_n && we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
        rd2_o = (ra2_i == '0) ? '0 : (rst_n && we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
    end
endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: directed self-checking bench for reg_file32
module tb_reg_file32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1, rd2;
    int checks = 0;
    int failures = 0;

    reg_file32 dut (
        .clk(clk), .rst_n(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1), .rd2_o(rd2)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ra1 = 5'd7; ra2 = 5'd31;
        @(posedge clk); #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'd0); end
        checks++; if (rd2 !== 32'd0) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'd0); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_write_readback;
        wr(5'd5, 32'd10);
        wr(5'd2, 32'd15);
        ra1 = 5'd2; ra2 = 5'd5; #1;
        checks++; if (rd1 !== 32'd15) begin failures++; $display("FAIL wr_rd1 got=%h exp=%h", rd1, 32'd15); end
        checks++; if (rd2 !== 32'd10) begin failures++; $display("FAIL wr_rd2 got=%h exp=%h", rd2, 32'd10); end
        we = 1'b0; wa = 5'd5; wd = 32'd99;
        repeat (3) @(posedge clk); #1;
        checks++; if (rd1 !== 32'd15) begin failures++; $display("FAIL hold_rd1 got=%h exp=%h", rd1, 32'd15); end
        checks++; if (rd2 !== 32'd10) begin failures++; $display("FAIL hold_rd2 got=%h exp=%h", rd2, 32'd10); end
    endtask

    task automatic test_write_zero;
        we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL r0_before got=%h exp=%h", rd1, 32'd0); end
        @(posedge clk); #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL r0_during got=%h exp=%h", rd1, 32'd0); end
        we = 1'b0; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL r0_after got=%h exp=%h", rd1, 32'd0); end
    endtask

    task automatic test_bypass;
        ra1 = 5'd9; ra2 = 5'd9; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL byp_pre got=%h exp=%h", rd1, 32'd0); end
        we = 1'b1; wa = 5'd9; wd = 32'h1234_5678; #1;
        checks++; if (rd1 !== 32'h1234_5678) begin failures++; $display("FAIL byp_rd1 got=%h exp=%h", rd1, 32'h1234_5678); end
        checks++; if (rd2 !== 32'h1234_5678) begin failures++; $display("FAIL byp_rd2 got=%h exp=%h", rd2, 32'h1234_5678); end
        @(posedge clk); #1;
        we = 1'b0; wd = 32'h0; #1;
        checks++; if (rd1 !== 32'h1234_5678) begin failures++; $display("FAIL byp_hold1 got=%h exp=%h", rd1, 32'h1234_5678); end
        checks++; if (rd2 !== 32'h1234_5678) begin failures++; $display("FAIL byp_hold2 got=%h exp=%h", rd2, 32'h1234_5678); end
        ra2 = 5'd2; we = 1'b1; wa = 5'd3; wd = 32'hAAAA_5555; #1;
        checks++; if (rd2 !== 32'd15) begin failures++; $display("FAIL byp_other got=%h exp=%h", rd2, 32'd15); end
        we = 1'b0; #1;
    endtask

    task automatic test_reset_mid;
        wr(5'd31, 32'hFFFF_FFFF);
        ra1 = 5'd31; ra2 = 5'd5; #1;
        checks++; if (rd1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL r31_set got=%h exp=%h", rd1, 32'hFFFF_FFFF); end
        #1 rst_n = 1'b0; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL async_clr got=%h exp=%h", rd1, 32'd0); end
        checks++; if (rd2 !== 32'd0) begin failures++; $display("FAIL async_clr5 got=%h exp=%h", rd2, 32'd0); end
        we = 1'b1; wa = 5'd31; wd = 32'h5A5A_5A5A; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL rst_nobyp got=%h exp=%h", rd1, 32'd0); end
        @(posedge clk); #1;
        we = 1'b0; rst_n = 1'b1; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL rst_nowr got=%h exp=%h", rd1, 32'd0); end
        wr(5'd31, 32'h0000_0055);
        checks++; if (rd1 !== 32'h55) begin failures++; $display("FAIL post_rst_wr got=%h exp=%h", rd1, 32'h55); end
    endtask

    task automatic test_sweep;
        for (int a = 1; a < 32; a++) wr(5'(a), 32'(a + 100));
        for (int a = 1; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(32 - a); #1;
            checks++; if (rd1 !== 32'(a + 100)) begin failures++; $display("FAIL sweep_rd1[%0d] got=%h exp=%h", a, rd1, 32'(a + 100)); end
            checks++; if (rd2 !== 32'(132 - a)) begin failures++; $display("FAIL sweep_rd2[%0d] got=%h exp=%h", 32 - a, rd2, 32'(132 - a)); end
        end
        ra1 = 5'd0; ra2 = 5'd0; #1;
        checks++; if (rd1 !== 32'd0) begin failures++; $display("FAIL sweep_r0_1 got=%h exp=%h", rd1, 32'd0); end
        checks++; if (rd2 !== 32'd0) begin failures++; $display("FAIL sweep_r0_2 got=%h exp=%h", rd2, 32'd0); end
    endtask

    initial begin
        test_reset;
        test_write_readback;
        test_write_zero;
        test_bypass;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
